fir_coeff_loader: RTL and testbench



---
 rtl/fir_coeff_loader.sv | 141 ++++++++++++++
 tb/tb_fir_coeff_loader.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_coeff_loader.sv
// Coefficient loader for a symmetric FIR: collects a serial tap stream into a
// shadow bank, verifies h[k] == h[N-1-k], and commits the shadow bank to the
// active bank only on a cycle the datapath marks safe via swap_ok.
module fir_coeff_loader #(
  parameter int unsigned FILTER_SIZE = 172,
  parameter int unsigned COEFF_W     = 16
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [COEFF_W-1:0]             coef_in,
  input  logic                           coef_valid,
  input  logic                           coef_last,
  output logic                           coef_ready,
  input  logic                           swap_ok,
  output logic [FILTER_SIZE*COEFF_W-1:0] coeff_bus,
  output logic                           coeff_updated,
  output logic                           load_error,
  output logic                           busy
);

  localparam int unsigned AW = $clog2(FILTER_SIZE);
  localparam logic [AW-1:0] LastIdx  = AW'(FILTER_SIZE - 1);
  localparam logic [AW-1:0] HalfLast = AW'(FILTER_SIZE / 2 - 1);

  typedef enum logic [2:0] {StIdle, StLoad, StDrain, StCheck, StSwap} state_e;

  state_e                           r_state;
  logic [AW-1:0]                    r_idx;
  logic [AW-1:0]                    r_k;
  logic [COEFF_W-1:0]               r_shadow [FILTER_SIZE];
  logic [FILTER_SIZE*COEFF_W-1:0]   r_bus;
  logic                             r_updated;
  logic                             r_error;

  logic                             w_xfer;
  logic                             w_wr_en;
  logic [AW-1:0]                    w_wr_addr;
  logic [AW-1:0]                    w_mirror;
  logic                             w_taps_match;
  logic [FILTER_SIZE*COEFF_W-1:0]   w_shadow_flat;

  assign coef_ready = !reset &&
                      (r_state == StIdle || r_state == StLoad || r_state == StDrain);
  assign w_xfer     = coef_valid && coef_ready;

  // DRAIN discards taps, so only IDLE and LOAD write the shadow bank.
  assign w_wr_en   = w_xfer && (r_state == StIdle || r_state == StLoad);
  assign w_wr_addr = (r_state == StLoad) ? r_idx : '0;

  assign w_mirror     = LastIdx - r_k;
  assign w_taps_match = (r_shadow[r_k] == r_shadow[w_mirror]);

  assign coeff_bus     = r_bus;
  assign coeff_updated = r_updated;
  assign load_error    = r_error;
  assign busy          = (r_state != StIdle);

  // Flatten the shadow bank into the active-bank layout.
  always_comb begin
    w_shadow_flat = '0;
    for (int k = 0; k < int'(FILTER_SIZE); k++) begin
      w_shadow_flat[k*COEFF_W +: COEFF_W] = r_shadow[k];
    end
  end

  // Shadow bank capture; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_shadow[w_wr_addr] <= coef_in;
    end
  end

  // Load / check / swap sequencing with registered pulse outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= StIdle;
      r_idx     <= '0;
      r_k       <= '0;
      r_bus     <= '0;
      r_updated <= 1'b0;
      r_error   <= 1'b0;
    end else begin
      r_updated <= 1'b0;
      r_error   <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (w_xfer) begin
            r_idx <= AW'(1);
            if (coef_last) begin
              r_error <= 1'b1;
            end else if (LastIdx == '0) begin
              r_state <= StIdle;
            end else begin
              r_state <= StLoad;
            end
          end
        end
        StLoad: begin
          if (w_xfer) begin
            if (r_idx == LastIdx) begin
              r_idx   <= '0;
              r_k     <= '0;
              r_state <= coef_last ? StCheck : StDrain;
            end else if (coef_last) begin
              r_idx   <= '0;
              r_error <= 1'b1;
              r_state <= StIdle;
            end else begin
              r_idx <= r_idx + AW'(1);
            end
          end
        end
        StDrain: begin
          if (w_xfer && coef_last) begin
            r_error <= 1'b1;
            r_state <= StIdle;
          end
        end
        StCheck: begin
          if (!w_taps_match) begin
            r_error <= 1'b1;
            r_state <= StIdle;
          end else if (r_k == HalfLast) begin
            r_state <= StSwap;
          end else begin
            r_k <= r_k + AW'(1);
          end
        end
        StSwap: begin
          if (swap_ok) begin
            r_bus     <= w_shadow_flat;
            r_updated <= 1'b1;
            r_state   <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_coeff_loader.sv
// Self-checking bench: drives an N=8 and an N=172 loader from a shared stream
// and checks the selected one against a transaction-level reference model.
module tb_fir_coeff_loader;

  localparam int unsigned W  = 16;
  localparam int unsigned NS = 8;
  localparam int unsigned NL = 172;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic [W-1:0]  coef_in;
  logic          coef_valid;
  logic          coef_last;
  logic          swap_ok;

  logic          rdy_s, upd_s, err_s, busy_s;
  logic          rdy_l, upd_l, err_l, busy_l;
  logic [NS*W-1:0] bus_s;
  logic [NL*W-1:0] bus_l;

  fir_coeff_loader #(.FILTER_SIZE(NS), .COEFF_W(W)) u_dut_small (
    .clk           (clk),
    .reset         (reset),
    .coef_in       (coef_in),
    .coef_valid    (coef_valid),
    .coef_last     (coef_last),
    .coef_ready    (rdy_s),
    .swap_ok       (swap_ok),
    .coeff_bus     (bus_s),
    .coeff_updated (upd_s),
    .load_error    (err_s),
    .busy          (busy_s)
  );

  fir_coeff_loader #(.FILTER_SIZE(NL), .COEFF_W(W)) u_dut_large (
    .clk           (clk),
    .reset         (reset),
    .coef_in       (coef_in),
    .coef_valid    (coef_valid),
    .coef_last     (coef_last),
    .coef_ready    (rdy_l),
    .swap_ok       (swap_ok),
    .coeff_bus     (bus_l),
    .coeff_updated (upd_l),
    .load_error    (err_l),
    .busy          (busy_l)
  );

  int n_checks = 0;
  int n_fails  = 0;

  logic          sel;      // 0: N=8 instance, 1: N=172 instance
  int            n_cur;
  logic [W-1:0]  mbank [NL];
  logic [W-1:0]  q_taps [$];

  function automatic logic d_rdy();  return sel ? rdy_l  : rdy_s;  endfunction
  function automatic logic d_upd();  return sel ? upd_l  : upd_s;  endfunction
  function automatic logic d_err();  return sel ? err_l  : err_s;  endfunction
  function automatic logic d_busy(); return sel ? busy_l : busy_s; endfunction
  function automatic logic [W-1:0] d_tap(input int k);
    if (sel) return bus_l[k*W +: W];
    return bus_s[k*W +: W];
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic check_bank(input string tag);
    for (int k = 0; k < n_cur; k++) begin
      check_eq($sformatf("%s bus[%0d]", tag, k), 32'(d_tap(k)), 32'(mbank[k]));
    end
  endtask

  task automatic clear_model();
    for (int k = 0; k < int'(NL); k++) mbank[k] = '0;
  endtask

  task automatic make_sym(input int n);
    q_taps.delete();
    for (int k = 0; k < n; k++) q_taps.push_back('0);
    for (int k = 0; k < n / 2; k++) begin
      q_taps[k]         = W'($urandom);
      q_taps[n - 1 - k] = q_taps[k];
    end
    if (n % 2 == 1) q_taps[n / 2] = W'($urandom);
  endtask

  // Sends q_taps back to back with coef_last on the final one; ends #1 after E0.
  task automatic send_taps(input string tag);
    int sz;
    sz = q_taps.size();
    for (int i = 0; i < sz; i++) begin
      int w;
      coef_valid = 1'b1;
      coef_in    = q_taps[i];
      coef_last  = (i == sz - 1);
      w = 0;
      while (!d_rdy() && w < 200) begin
        @(posedge clk); #1;
        w++;
      end
      check_eq($sformatf("%s ready tap%0d", tag, i), 32'(d_rdy()), 32'd1);
      @(posedge clk); #1;
      if (i < sz - 1) begin
        check_eq($sformatf("%s early upd tap%0d", tag, i), 32'(d_upd()), 32'd0);
        check_eq($sformatf("%s early err tap%0d", tag, i), 32'(d_err()), 32'd0);
      end
    end
    coef_valid = 1'b0;
    coef_last  = 1'b0;
  endtask

  // Predicts the outcome from the load rules, then checks cycle by cycle.
  task automatic run_load(input int swap_on, input string tag);
    int l, n, mis, exp_err, exp_upd, end_c;
    l = q_taps.size();
    n = n_cur;
    exp_err = -1;
    exp_upd = -1;
    if (l != n) begin
      exp_err = 0;
    end else begin
      mis = -1;
      for (int k = 0; k < n / 2; k++) begin
        if (mis < 0 && q_taps[k] != q_taps[n - 1 - k]) mis = k;
      end
      if (mis >= 0) exp_err = mis + 1;
      else exp_upd = (swap_on + 1 > n / 2 + 1) ? swap_on + 1 : n / 2 + 1;
    end
    end_c = (exp_upd >= 0) ? exp_upd : exp_err;
    swap_ok = (swap_on == 0);
    send_taps(tag);
    for (int c = 0; c <= end_c + 1; c++) begin
      if (c == exp_upd) begin
        for (int k = 0; k < n; k++) mbank[k] = q_taps[k];
      end
      check_eq($sformatf("%s upd c%0d", tag, c), 32'(d_upd()), 32'(c == exp_upd));
      check_eq($sformatf("%s err c%0d", tag, c), 32'(d_err()), 32'(c == exp_err));
      check_eq($sformatf("%s busy c%0d", tag, c), 32'(d_busy()), 32'(c < end_c));
      check_eq($sformatf("%s ready c%0d", tag, c), 32'(d_rdy()), 32'(c >= end_c));
      check_eq($sformatf("%s tap0 c%0d", tag, c), 32'(d_tap(0)), 32'(mbank[0]));
      check_eq($sformatf("%s tapN c%0d", tag, c), 32'(d_tap(n - 1)), 32'(mbank[n - 1]));
      swap_ok = (c >= swap_on);
      @(posedge clk); #1;
    end
    check_bank(tag);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    coef_valid = 1'b0;
    coef_last = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    clear_model();
    check_eq("rst ready", 32'(d_rdy()), 32'd0);
    check_eq("rst upd", 32'(d_upd()), 32'd0);
    check_eq("rst err", 32'(d_err()), 32'd0);
    check_eq("rst busy", 32'(d_busy()), 32'd0);
    check_bank("rst");
    reset = 1'b0;
    #1;
    check_eq("post-rst ready", 32'(d_rdy()), 32'd1);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] base [NS];
    base[0] = 16'h0100; base[1] = 16'h0200; base[2] = 16'h0300; base[3] = 16'h0400;
    base[4] = 16'h0400; base[5] = 16'h0300; base[6] = 16'h0200; base[7] = 16'h0100;
    coef_in = '0;
    swap_ok = 1'b1;
    sel = 1'b0;
    n_cur = NS;
    do_reset();

    // Symmetric load, commit 5 edges after the last tap.
    q_taps.delete();
    for (int k = 0; k < int'(NS); k++) q_taps.push_back(base[k]);
    run_load(0, "sym");
    check_eq("sym bus[15:0]", 32'(bus_s[15:0]), 32'h0100);
    check_eq("sym bus[127:112]", 32'(bus_s[127:112]), 32'h0100);

    // Asymmetric: mismatch at k=1.
    q_taps[6] = 16'h0201;
    run_load(0, "asym");

    // Underrun: coef_last on tap 5.
    q_taps.delete();
    for (int k = 0; k < 5; k++) q_taps.push_back(W'($urandom));
    run_load(0, "under");

    // Overrun: 10 taps, last on the 10th.
    q_taps.delete();
    for (int k = 0; k < 10; k++) q_taps.push_back(W'($urandom));
    run_load(0, "over");

    // Single tap with coef_last straight from IDLE.
    q_taps.delete();
    q_taps.push_back(W'($urandom));
    run_load(0, "one");

    // swap_ok held low 20 cycles after SWAP is entered.
    make_sym(NS);
    run_load(NS / 2 + 20, "gate");

    // Random symmetric and asymmetric loads with random swap timing.
    for (int t = 0; t < 6; t++) begin
      make_sym(NS);
      if (t % 2 == 1) begin
        int k;
        k = int'($urandom_range(NS / 2 - 1, 0));
        q_taps[NS - 1 - k] = q_taps[NS - 1 - k] ^ W'(1 << $urandom_range(W - 1, 0));
      end
      run_load(int'($urandom_range(10, 0)), $sformatf("rnd%0d", t));
    end

    // Reset during tap 3 of a new load.
    make_sym(NS);
    swap_ok = 1'b1;
    for (int i = 0; i < 2; i++) begin
      coef_valid = 1'b1;
      coef_in = q_taps[i];
      coef_last = 1'b0;
      @(posedge clk); #1;
    end
    coef_in = q_taps[2];
    reset = 1'b1;
    #1;
    check_eq("midrst ready", 32'(d_rdy()), 32'd0);
    @(posedge clk); #1;
    clear_model();
    check_eq("midrst upd", 32'(d_upd()), 32'd0);
    check_eq("midrst err", 32'(d_err()), 32'd0);
    check_eq("midrst busy", 32'(d_busy()), 32'd0);
    check_bank("midrst");
    reset = 1'b0;
    coef_valid = 1'b0;
    #1;
    check_eq("midrst ready after", 32'(d_rdy()), 32'd1);
    make_sym(NS);
    run_load(0, "after-rst");

    // Default size instance.
    sel = 1'b1;
    n_cur = NL;
    do_reset();
    make_sym(NL);
    run_load(0, "big-sym");
    make_sym(NL);
    q_taps[NL - 1 - 40] = q_taps[NL - 1 - 40] ^ 16'h8000;
    run_load(0, "big-asym");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
